// File: rtl/mat_config_arbiter.sv
// rtl/mat_config_arbiter.sv - match-action table config sequencer: default-value init walk, then round-robin write arbitration
module mat_config_arbiter #(
  parameter int                     KEY_WIDTH   = 8,
  parameter int                     VALUE_WIDTH = 128,
  parameter int                     TABLE_DEPTH = 8,
  parameter logic [VALUE_WIDTH-1:0] INIT_VALUE  = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_start,
  input  logic                   req0_valid,
  input  logic [KEY_WIDTH-1:0]   req0_key,
  input  logic [VALUE_WIDTH-1:0] req0_value,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic [KEY_WIDTH-1:0]   req1_key,
  input  logic [VALUE_WIDTH-1:0] req1_value,
  output logic                   req1_ready,
  output logic                   m_mat_en,
  output logic [KEY_WIDTH-1:0]   m_mat_key,
  output logic [VALUE_WIDTH-1:0] m_mat_value,
  output logic                   init_busy,
  output logic                   err_key,
  output logic [15:0]            wr_count
);

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TABLE_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   rr_q, rr_d;
  logic                   en_q, en_d;
  logic [KEY_WIDTH-1:0]   key_q, key_d;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;

  logic                   grant0, grant1;
  logic [KEY_WIDTH-1:0]   sel_key;
  logic [VALUE_WIDTH-1:0] sel_value;
  logic                   key_in_range;

  // rr_q=0 favours req0 when both are valid; init_start blocks any grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_IDLE && !init_start) begin
      grant0 = req0_valid & (~req1_valid | ~rr_q);
      grant1 = req1_valid & (~req0_valid | rr_q);
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign sel_key      = grant1 ? req1_key : req0_key;
  assign sel_value    = grant1 ? req1_value : req0_value;
  assign key_in_range = (sel_key >> IDX_W) == '0;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    en_d    = 1'b0;
    key_d   = key_q;
    value_d = value_q;
    busy_d  = (state_q == ST_INIT);
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        en_d    = 1'b1;
        key_d   = KEY_WIDTH'(idx_q);
        value_d = INIT_VALUE;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        if (init_start) begin
          state_d = ST_INIT;
          idx_d   = '0;
        end else if (grant0 | grant1) begin
          rr_d = grant0;
          if (key_in_range) begin
            en_d    = 1'b1;
            key_d   = sel_key;
            value_d = sel_value;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
      rr_q    <= 1'b0;
      en_q    <= 1'b0;
      key_q   <= '0;
      value_q <= '0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      en_q    <= en_d;
      key_q   <= key_d;
      value_q <= value_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m_mat_en    = en_q;
  assign m_mat_key   = key_q;
  assign m_mat_value = value_q;
  assign init_busy   = busy_q;
  assign err_key     = err_q;
  assign wr_count    = cnt_q;

endmodule

// File: tb/tb_mat_config_arbiter.sv
// tb/tb_mat_config_arbiter.sv - randomized bench for mat_config_arbiter against a behavioural table-writer model
module tb_mat_config_arbiter;
  localparam int KW = 8;
  localparam int VW = 128;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_start = 1'b0;
  logic          req0_valid = 1'b0;
  logic [KW-1:0] req0_key = '0;
  logic [VW-1:0] req0_value = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [KW-1:0] req1_key = '0;
  logic [VW-1:0] req1_value = '0;
  logic          req1_ready;
  logic          m_mat_en;
  logic [KW-1:0] m_mat_key;
  logic [VW-1:0] m_mat_value;
  logic          init_busy;
  logic          err_key;
  logic [15:0]   wr_count;

  always #5 clk = ~clk;

  mat_config_arbiter #(
    .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TABLE_DEPTH(DEPTH), .INIT_VALUE('0)
  ) dut (
    .clk(clk), .rst(rst), .init_start(init_start),
    .req0_valid(req0_valid), .req0_key(req0_key), .req0_value(req0_value), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_key(req1_key), .req1_value(req1_value), .req1_ready(req1_ready),
    .m_mat_en(m_mat_en), .m_mat_key(m_mat_key), .m_mat_value(m_mat_value),
    .init_busy(init_busy), .err_key(err_key), .wr_count(wr_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: "walking" with a count of default writes still owed, a favoured requester, expected outputs.
  bit            m_walking;
  int            m_left;
  bit            m_fav;
  bit            m_en;
  int            m_key;
  logic [VW-1:0] m_val;
  bit            m_busy;
  bit            m_err;
  int            m_cnt;
  bit            m_r0, m_r1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_walking = 1'b1;
    m_left    = DEPTH;
    m_fav     = 1'b0;
    m_en      = 1'b0;
    m_key     = 0;
    m_val     = '0;
    m_busy    = 1'b1;
    m_err     = 1'b0;
    m_cnt     = 0;
    m_r0      = 1'b0;
    m_r1      = 1'b0;
  endtask

  task automatic check_outputs();
    chk("m_mat_en", 128'(m_mat_en), 128'(m_en));
    chk("m_mat_key", 128'(m_mat_key), 128'(m_key));
    chk("m_mat_value", m_mat_value, m_val);
    chk("init_busy", 128'(init_busy), 128'(m_busy));
    chk("err_key", 128'(err_key), 128'(m_err));
    chk("wr_count", 128'(wr_count), 128'(m_cnt));
  endtask

  // Inputs are already driven (at a negedge); check readys, advance the model one edge, check outputs.
  task automatic tick();
    bit            was_walking;
    int            k;
    logic [VW-1:0] v;
    #1;
    if (m_walking || init_start) begin
      m_r0 = 1'b0;
      m_r1 = 1'b0;
    end else if (req0_valid && req1_valid) begin
      m_r0 = !m_fav;
      m_r1 = m_fav;
    end else begin
      m_r0 = req0_valid;
      m_r1 = req1_valid;
    end
    chk("req0_ready", 128'(req0_ready), 128'(m_r0));
    chk("req1_ready", 128'(req1_ready), 128'(m_r1));
    was_walking = m_walking;
    m_err = 1'b0;
    if (m_walking) begin
      m_en  = 1'b1;
      m_key = DEPTH - m_left;
      m_val = '0;
      m_left--;
      if (m_left == 0) m_walking = 1'b0;
    end else if (init_start) begin
      m_walking = 1'b1;
      m_left    = DEPTH;
      m_en      = 1'b0;
    end else if (m_r0 || m_r1) begin
      k     = m_r0 ? int'(req0_key) : int'(req1_key);
      v     = m_r0 ? req0_value : req1_value;
      m_fav = m_r0;
      if (k < DEPTH) begin
        m_en  = 1'b1;
        m_key = k;
        m_val = v;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        m_en  = 1'b0;
        m_err = 1'b1;
      end
    end else begin
      m_en = 1'b0;
    end
    m_busy = was_walking;
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [VW-1:0] rand_value();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int guard;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // power-up walk
    repeat (DEPTH + 2) tick();

    // both requesters continuously valid: alternate grants
    req0_valid = 1'b1; req0_key = 8'd1; req0_value = 128'hA;
    req1_valid = 1'b1; req1_key = 8'd2; req1_value = 128'hB;
    repeat (6) tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

    // out-of-range key accepted but not written, then an in-range write
    req1_valid = 1'b1; req1_key = 8'd9; req1_value = rand_value();
    tick();
    req1_key = 8'd3; req1_value = rand_value();
    tick();
    req1_valid = 1'b0;
    tick();

    // init_start in IDLE beats a pending request
    req0_valid = 1'b1; req0_key = 8'd5; req0_value = rand_value();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (DEPTH + 1) tick();
    req0_valid = 1'b0;
    tick();

    // init_start mid-walk is ignored
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (4) tick();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (DEPTH) tick();

    // async reset mid-walk restarts from key 0
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
    repeat (DEPTH + 2) tick();

    // randomized traffic; a requester holds its request until accepted
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || m_r0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_key   = KW'($urandom_range(0, 15));
        req0_value = rand_value();
      end
      if (!req1_valid || m_r1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_key   = KW'($urandom_range(0, 15));
        req1_value = rand_value();
      end
      init_start = ($urandom_range(0, 40) == 0);
      tick();
    end
    init_start = 1'b0;
    req1_valid = 1'b0;

    // drive wr_count into saturation
    req0_valid = 1'b1; req0_key = 8'd6; req0_value = 128'h5A5A;
    guard = 0;
    while (m_cnt < 65535 && guard < 70000) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("wr_count_saturated", 128'(wr_count), 128'h0FFFF);
    req0_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
